filt_window_addr_gen: RTL and testbench

Parametrised address generator for filter accelerators. It supports the legacy 1x1 mode, with one linear address per pixel, and a KxK window mode, which emits all K*K neighbourhood addresses for each output pixel in raster order. Configurable inter-address gap cycles throttle the memory port. It sits between the accelerator control FSM and the input memory read port.

---
 rtl/filt_window_addr_gen.sv | 178 +++++++++++++++++
 tb/tb_filt_window_addr_gen.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/filt_window_addr_gen.sv
// Read-address generator for filter accelerators: emits one linear address per
// pixel (mode 0) or the full KxK neighbourhood per pixel in raster order (mode 1).
module filt_window_addr_gen #(
  parameter int ADDR_W = 32,
  parameter int K      = 3,
  parameter int GAP    = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              pause,
  input  logic              mode,
  input  logic [ADDR_W-1:0] filesize,
  input  logic [ADDR_W-1:0] row_width,
  output logic [ADDR_W-1:0] addr,
  output logic              valid,
  output logic              win_last,
  output logic              oob,
  output logic              done
);

  localparam int IDX_W = (K > 1) ? $clog2(K) : 1;
  localparam int GAP_W = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam logic [IDX_W-1:0] K_M1     = IDX_W'(K - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP);

  typedef enum logic [1:0] {IDLE, STEP, GAPW, DONE} state_t;

  // After each issue the FSM either idles in GAPW or is immediately ready again.
  localparam state_t ISSUE_STATE = (GAP > 0) ? GAPW : STEP;

  state_t            state_q, state_d;
  logic              mode_q, mode_d;
  logic [ADDR_W-1:0] fs_q, fs_d;
  logic [ADDR_W-1:0] rw_q, rw_d;
  logic [ADDR_W-1:0] pix_q, pix_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [IDX_W-1:0]  r_q, r_d;
  logic [IDX_W-1:0]  c_q, c_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [ADDR_W-1:0] addr_d;
  logic              valid_d, win_last_d, oob_d, done_d;

  logic [IDX_W-1:0]  kx_m1, r_n, c_n;
  logic [ADDR_W-1:0] pix_n, base_n, addr_n;
  logic              last_issued;

  // Candidate next window position; base tracks r*row_width without a multiplier.
  always_comb begin : advance
    kx_m1  = mode_q ? K_M1 : '0;
    pix_n  = pix_q;
    base_n = base_q;
    r_n    = r_q;
    c_n    = c_q;
    if (c_q != kx_m1) begin
      c_n = c_q + IDX_W'(1);
    end else if (r_q != kx_m1) begin
      c_n    = '0;
      r_n    = r_q + IDX_W'(1);
      base_n = base_q + rw_q;
    end else begin
      c_n    = '0;
      r_n    = '0;
      base_n = '0;
      pix_n  = pix_q + ADDR_W'(1);
    end
    addr_n      = pix_n + base_n + ADDR_W'(c_n);
    last_issued = (pix_q == fs_q - ADDR_W'(1)) && (r_q == kx_m1) && (c_q == kx_m1);
  end

  always_comb begin : next_state
    // NOTE: every *_d gets a hold default before the case so no branch can infer a latch.
    state_d    = state_q;
    mode_d     = mode_q;
    fs_d       = fs_q;
    rw_d       = rw_q;
    pix_d      = pix_q;
    base_d     = base_q;
    r_d        = r_q;
    c_d        = c_q;
    gap_d      = gap_q;
    addr_d     = addr;
    valid_d    = 1'b0;
    win_last_d = win_last;
    oob_d      = oob;
    done_d     = done;

    case (state_q)
      IDLE: begin
        if (enable) begin
          mode_d = mode;
          fs_d   = filesize;
          rw_d   = row_width;
          pix_d  = '0;
          base_d = '0;
          r_d    = '0;
          c_d    = '0;
          if (filesize == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            addr_d     = '0;
            valid_d    = 1'b1;
            win_last_d = (mode == 1'b0) || (K_M1 == '0);
            oob_d      = 1'b0;
            gap_d      = GAP_LOAD;
            state_d    = ISSUE_STATE;
          end
        end
      end

      GAPW: begin
        gap_d = gap_q - GAP_W'(1);
        if (gap_q == GAP_W'(1)) state_d = STEP;
      end

      STEP: begin
        if (!pause) begin
          if (last_issued) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            pix_d      = pix_n;
            base_d     = base_n;
            r_d        = r_n;
            c_d        = c_n;
            addr_d     = addr_n;
            valid_d    = 1'b1;
            win_last_d = (r_n == kx_m1) && (c_n == kx_m1);
            oob_d      = (addr_n >= fs_q);
            gap_d      = GAP_LOAD;
            state_d    = ISSUE_STATE;
          end
        end
      end

      DONE: done_d = 1'b1;

      default: state_d = IDLE;
    endcase
  end

  // NOTE: non-blocking assignments so every flop samples values from before the edge.
  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      state_q  <= IDLE;
      mode_q   <= 1'b0;
      fs_q     <= '0;
      rw_q     <= '0;
      pix_q    <= '0;
      base_q   <= '0;
      r_q      <= '0;
      c_q      <= '0;
      gap_q    <= '0;
      addr     <= '1;
      valid    <= 1'b0;
      win_last <= 1'b0;
      oob      <= 1'b0;
      done     <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      fs_q     <= fs_d;
      rw_q     <= rw_d;
      pix_q    <= pix_d;
      base_q   <= base_d;
      r_q      <= r_d;
      c_q      <= c_d;
      gap_q    <= gap_d;
      addr     <= addr_d;
      valid    <= valid_d;
      win_last <= win_last_d;
      oob      <= oob_d;
      done     <= done_d;
    end
  end

endmodule

// File: tb/tb_filt_window_addr_gen.sv
// Scoreboard bench for filt_window_addr_gen: a GAP=1 and a GAP=0 instance share
// config inputs; expected addresses are queued by stimulus and popped by a monitor.
module tb_filt_window_addr_gen;

  localparam int AW   = 32;
  localparam int TB_K = 3;
  localparam logic [AW-1:0] ALL_ONES = {AW{1'b1}};

  typedef struct {
    logic [AW-1:0] a;
    logic          wl;
    logic          oob;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset, pause, mode;
  logic          en0, en1;
  logic [AW-1:0] filesize, row_width;
  logic [AW-1:0] addr0, addr1;
  logic          valid0, valid1, wl0, wl1, oob0, oob1, done0, done1;

  int n_tests = 0;
  int n_fail  = 0;

  exp_t          q0[$];
  exp_t          q1[$];
  logic [AW-1:0] obs_a[$];
  logic          obs_wl[$];
  logic          obs_oob[$];

  always #5 clk = ~clk;

  filt_window_addr_gen #(.ADDR_W(AW), .K(TB_K), .GAP(1)) u_g1 (
    .clk(clk), .reset(reset), .enable(en1), .pause(pause), .mode(mode),
    .filesize(filesize), .row_width(row_width), .addr(addr1), .valid(valid1),
    .win_last(wl1), .oob(oob1), .done(done1)
  );

  filt_window_addr_gen #(.ADDR_W(AW), .K(TB_K), .GAP(0)) u_g0 (
    .clk(clk), .reset(reset), .enable(en0), .pause(pause), .mode(mode),
    .filesize(filesize), .row_width(row_width), .addr(addr0), .valid(valid0),
    .win_last(wl0), .oob(oob0), .done(done0)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference order: pixel outer, then row, then column; address by direct multiply.
  task automatic push_run(input bit to_g1, input bit m, input int fs, input int rw,
                          input int max_n);
    int   kx;
    int   n;
    exp_t e;
    kx = m ? TB_K : 1;
    n  = 0;
    for (int p = 0; p < fs; p++)
      for (int r = 0; r < kx; r++)
        for (int c = 0; c < kx; c++) begin
          if (n < max_n) begin
            e.a   = AW'(p + r * rw + c);
            e.wl  = (r == kx - 1) && (c == kx - 1);
            e.oob = (e.a >= AW'(fs));
            if (to_g1) q1.push_back(e);
            else       q0.push_back(e);
          end
          n++;
        end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input bit g1, input int budget, input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      seen = g1 ? done1 : done0;
    end
    check(name, seen, 1'b1);
  endtask

  task automatic check_reset_vals(input string name);
    check({name, "_addr"},  addr1,  ALL_ONES);
    check({name, "_valid"}, valid1, 1'b0);
    check({name, "_done"},  done1,  1'b0);
    check({name, "_wl"},    wl1,    1'b0);
    check({name, "_oob"},   oob1,   1'b0);
  endtask

  // Monitor: every valid address must match the head of its instance's queue.
  exp_t e0, e1;
  always @(negedge clk) begin
    if (valid0) begin
      obs_a.push_back(addr0);
      obs_wl.push_back(wl0);
      obs_oob.push_back(oob0);
      if (q0.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL g0_unexpected_valid: got addr %0h, expected no valid", addr0);
      end else begin
        e0 = q0.pop_front();
        check("g0_addr", addr0, e0.a);
        check("g0_win_last", wl0, e0.wl);
        check("g0_oob", oob0, e0.oob);
      end
    end
    if (valid1) begin
      if (q1.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL g1_unexpected_valid: got addr %0h, expected no valid", addr1);
      end else begin
        e1 = q1.pop_front();
        check("g1_addr", addr1, e1.a);
        check("g1_win_last", wl1, e1.wl);
        check("g1_oob", oob1, e1.oob);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_first[9];
    int exp_last[9];
    int n_valid;
    int done_cyc;
    bit found;

    exp_first = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
    exp_last  = '{15, 16, 17, 19, 20, 21, 23, 24, 25};

    reset = 1'b1; en0 = 1'b0; en1 = 1'b0; pause = 1'b0; mode = 1'b0;
    filesize = '0; row_width = '0;
    tick();
    tick();
    check_reset_vals("reset_state");
    reset = 1'b0;

    // Mode 0, GAP=1, fs=4: valid on cycles 1,3,5,7; done from cycle 9.
    filesize = 4;
    push_run(1'b1, 1'b0, 4, 0, 1000);
    en1 = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      check($sformatf("t1_valid_c%0d", i), valid1, (i % 2 == 1) && (i <= 7));
      check($sformatf("t1_done_c%0d", i), done1, i >= 9);
    end
    check("t1_done_addr_hold", addr1, 3);
    en1 = 1'b0;
    tick();

    // Mode 1, K=3, GAP=0, rw=4, fs=16; config toggled mid-run must be ignored.
    mode = 1'b1; filesize = 16; row_width = 4;
    obs_a.delete(); obs_wl.delete(); obs_oob.delete();
    push_run(1'b0, 1'b1, 16, 4, 1000);
    en0 = 1'b1;
    n_valid = 0;
    done_cyc = 0;
    for (int cyc = 1; cyc <= 300 && done_cyc == 0; cyc++) begin
      tick();
      if (valid0) n_valid++;
      if (done0) done_cyc = cyc;
      if (cyc == 50) begin
        mode = 1'b0; filesize = 5; row_width = 7;
      end
    end
    check("t2_valid_count", n_valid, 144);
    check("t2_done_cycle", done_cyc, 145);
    check("t2_obs_size", obs_a.size(), 144);
    for (int i = 0; i < 9; i++) begin
      check($sformatf("t2_first_addr%0d", i), obs_a[i], exp_first[i]);
      check($sformatf("t2_first_wl%0d", i), obs_wl[i], i == 8);
      check($sformatf("t2_pix15_addr%0d", i), obs_a[135 + i], exp_last[i]);
      check($sformatf("t2_pix15_oob%0d", i), obs_oob[135 + i], i != 0);
    end
    check("t2_pix1_start", obs_a[9], 1);
    en0 = 1'b0;
    tick();
    check("t2_idle_addr", addr0, ALL_ONES);

    // Mode 0, GAP=0: pause for 3 cycles after addr 2.
    mode = 1'b0; filesize = 8; row_width = 0;
    push_run(1'b0, 1'b0, 8, 0, 1000);
    en0 = 1'b1;
    repeat (3) tick();
    check("t3_pre_pause_valid", valid0, 1'b1);
    check("t3_pre_pause_addr", addr0, 2);
    pause = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("t3_pause_valid%0d", i), valid0, 1'b0);
      check($sformatf("t3_pause_addr%0d", i), addr0, 2);
    end
    pause = 1'b0;
    tick();
    check("t3_resume_valid", valid0, 1'b1);
    check("t3_resume_addr", addr0, 3);
    wait_done(1'b0, 20, "t3_done");
    check("t3_queue_drained", q0.size(), 0);
    en0 = 1'b0;

    // GAP=1: drop enable at addr 5, re-raise after 2 cycles.
    filesize = 10;
    push_run(1'b1, 1'b0, 10, 0, 6);
    en1 = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      found = valid1 && (addr1 == 5);
    end
    check("t4_reached_addr5", found, 1'b1);
    en1 = 1'b0;
    tick();
    check("t4_idle_addr", addr1, ALL_ONES);
    check("t4_idle_done", done1, 1'b0);
    check("t4_idle_valid", valid1, 1'b0);
    check("t4_queue_drained", q1.size(), 0);
    tick();
    push_run(1'b1, 1'b0, 10, 0, 1000);
    en1 = 1'b1;
    tick();
    check("t4_restart_valid", valid1, 1'b1);
    check("t4_restart_addr", addr1, 0);
    wait_done(1'b1, 60, "t4_done");

    // Reset in DONE, then again in GAPW, with enable held high.
    filesize = 3;
    reset = 1'b1;
    tick();
    check_reset_vals("t5_reset_in_done");
    reset = 1'b0;
    push_run(1'b1, 1'b0, 3, 0, 1);
    tick();
    check("t5_restart_valid", valid1, 1'b1);
    check("t5_restart_addr", addr1, 0);
    reset = 1'b1;
    tick();
    check_reset_vals("t5_reset_in_gapw");
    reset = 1'b0;
    push_run(1'b1, 1'b0, 3, 0, 1000);
    tick();
    check("t5_restart2_valid", valid1, 1'b1);
    check("t5_restart2_addr", addr1, 0);
    wait_done(1'b1, 20, "t5_done");
    check("t5_done_addr_hold", addr1, 2);
    en1 = 1'b0;

    // fs = 0: done next cycle, valid never asserts.
    filesize = 0;
    en0 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("t6_done%0d", i), done0, 1'b1);
      check($sformatf("t6_valid%0d", i), valid0, 1'b0);
    end
    en0 = 1'b0;
    tick();

    check("final_q0_empty", q0.size(), 0);
    check("final_q1_empty", q1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
